ifu: RTL
========

# ifu

Instruction fetch unit for the single-cycle MIPS core. It owns the PC register and fetches instruction words over a req/ack handshake to instruction memory. It presents `opcode`/`func` to the `control` decoder and applies the decoder's redirect outputs (`nPC_sel`, `j_src`, `j_zero`) together with the ALU `zero` flag to compute the next PC. The datapath gates every architectural write with `instr_valid`.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `nPC_sel` in 1: redirect request from `control`.
- `j_src` in 2: redirect source. 00 = branch, 01 = jal, 10 = jr, 11 = reserved.
- `j_zero` in 2: branch condition. Bit 0 means taken when `zero`=1; bit 1 is reserved and read as 0.
- `zero` in 1: ALU equality flag for the current instruction.
- `jr_target` in 32: GPR[rs] value for jr.
- `hold` in 1: extends EXEC, for datapath wait.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_ack` in 1: `imem_rdata` is valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: registered instruction.
- `opcode` out 6: `instr[31:26]`.
- `func` out 6: `instr[5:0]`.
- `instr_valid` out 1: high in EXEC.
- `pc` out 32: address of `instr`.
- `pc_plus4` out 32: `pc`+4, the jal link value.

## Operation
- FSM has two states, FETCH and EXEC. Reset state is FETCH.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until ack.
  - When `imem_ack`=1: `instr` ← `imem_rdata` and the state goes to EXEC.
- **EXEC**
  - `instr_valid`=1 and `imem_req`=0. `imem_ack` is ignored.
  - If `hold`=1: stay in EXEC, with `pc` and `instr` unchanged.
  - Otherwise: `pc` ← `npc` and the state goes to FETCH.
- **Next-PC selection**, evaluated combinationally in EXEC:
  - `nPC_sel`=0: `pc_plus4`.
  - `nPC_sel`=1, `j_src`=00: `pc_plus4` + (sext(`instr[15:0]`) << 2) if `j_zero[0]` && `zero`, else `pc_plus4`.
  - `nPC_sel`=1, `j_src`=01: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - `nPC_sel`=1, `j_src`=10: {`jr_target[31:2]`, 2'b00}. Misaligned low bits are silently cleared.
  - `j_src`=11: `pc_plus4`.
- All PC arithmetic is 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 0. Backward branches wrap the same way.
- **Reset values**
  - `pc` = `RESET_PC`; `instr` = 0 (nop); `opcode` = `func` = 0.
  - `instr_valid` = 0; `imem_req` = 1 (FETCH).
  - `pc_plus4` = `RESET_PC`+4.
- **Reset mid-operation**: an outstanding fetch is abandoned. After reset `imem_req` stays high with `imem_addr` = `RESET_PC`, and memory must tolerate the address change under req. An ack arriving in the same cycle as reset assertion is discarded.

## Timing
- Fetch latency is 1 cycle plus the memory wait. With a zero-wait memory (ack in the first FETCH cycle), each instruction takes 2 cycles: FETCH, then EXEC.
- The `instr` register updates on the ack edge, so `opcode`/`func` are valid from the first EXEC cycle.
- `control` outputs and `zero` are sampled only on the EXEC edge with `hold`=0. Their values in FETCH are don't-care.
- `pc` changes only on the EXEC→FETCH edge.
- `imem_addr` is glitch-free within FETCH because it is driven from a register.
- `hold` is evaluated every EXEC cycle. N cycles of `hold` give N+1 EXEC cycles, with `instr_valid` high throughout. The datapath must gate its writes with `instr_valid && !hold`.

## Structure
- Package `mips_pkg` holds:
  - `j_src` encodings `JSRC_BR`=0, `JSRC_JAL`=1, `JSRC_JR`=2.
  - the FSM state type {FETCH, EXEC}.
  - the default reset PC constant 32'h0000_3000.
- Sub-module `npc`: purely combinational next-PC mux. Inputs are `pc_plus4`, `instr[25:0]`, `jr_target`, `nPC_sel`, `j_src`, `j_zero`, `zero`; output is `npc`.
- `ifu` itself contains the FSM, the PC register and the `instr` register.

## Test plan
- **Reset and sequential fetch**: release `rst_n`, zero-wait memory returning nops. Required: `imem_addr` = 3000, 3004, 3008 in successive FETCH cycles; `instr_valid` is high every second cycle.
- **Wait states**: ack delayed 3 cycles. Required: `imem_addr` = 3000 stable for 3 cycles with `imem_req` high; EXEC follows the ack; `pc` stays 3000 until EXEC ends.
- **beq at 3010 with offset 16'hFFFC**: with `zero`=1, next `pc` = 3004. With `zero`=0, next `pc` = 3014.
- **jal and jr**: jal with index 26'h0000C05 at pc 3000 gives `pc` = 3014 and `pc_plus4` = 3004 during EXEC. jr with `jr_target` = 32'h0000_3023 gives `pc` = 3020.
- **hold and wrap**: `hold`=1 for 2 cycles holds `pc` and `instr`, and `instr_valid` stays high for 3 cycles. A nop at FFFF_FFFC makes the next fetch address 0000_0000.
- **Reset mid-fetch**: assert `rst_n`=0 while waiting on address 3008, with ack pulsing in the same cycle. Required: `pc` = 3000, `instr` = 0, state FETCH, and no EXEC cycle occurs.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
// Holds the redirect source encodings, the fetch FSM state type and the reset PC.
package mips_pkg;

    localparam logic [1:0]  JSRC_BR  = 2'd0;
    localparam logic [1:0]  JSRC_JAL = 2'd1;
    localparam logic [1:0]  JSRC_JR  = 2'd2;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } ifu_state_t;

endpackage

// File: rtl/ifu_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface ifu_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/npc.sv
// Combinational next-PC selection from the decoder's redirect controls.
module npc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_idx,
    input  logic [31:0] jr_target,
    input  logic        nPC_sel,
    input  logic [1:0]  j_src,
    input  logic [1:0]  j_zero,
    input  logic        zero,
    output logic [31:0] npc
);

    logic [31:0] br_off;
    logic        unused_ok;

    assign br_off    = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
    // Reserved condition bit and jr low bits are intentionally ignored.
    assign unused_ok = ^{j_zero[1], jr_target[1:0]};

    always_comb begin
        npc = pc_plus4;
        if (nPC_sel) begin
            case (j_src)
                JSRC_BR:  if (j_zero[0] && zero) npc = pc_plus4 + br_off;
                JSRC_JAL: npc = {pc_plus4[31:28], instr_idx, 2'b00};
                JSRC_JR:  npc = {jr_target[31:2], 2'b00};
                default:  npc = pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, instruction register and the FETCH/EXEC
// sequencer driving the imem req/ack handshake.
module ifu
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nPC_sel,
    input  logic [1:0]  j_src,
    input  logic [1:0]  j_zero,
    input  logic        zero,
    input  logic [31:0] jr_target,
    input  logic        hold,
    ifu_if.master       imem,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, instr_q, npc_w;
    logic        pc_load, instr_load, req;

    npc u_npc (
        .pc_plus4  (pc_plus4),
        .instr_idx (instr_q[25:0]),
        .jr_target (jr_target),
        .nPC_sel   (nPC_sel),
        .j_src     (j_src),
        .j_zero    (j_zero),
        .zero      (zero),
        .npc       (npc_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (pc_load)    pc_q    <= npc_w;
            if (instr_load) instr_q <= imem.imem_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_load     = 1'b0;
        instr_load  = 1'b0;
        req         = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    instr_load = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!hold) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Address comes straight from the PC register, so it cannot glitch under req.
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign instr    = instr_q;
    assign opcode   = instr_q[31:26];
    assign func     = instr_q[5:0];

endmodule
